// File: rtl/pc_predict_unit.sv
// Fetch-side PC generator: registered PC prediction, jump/ret correction select
// and a circular return-address stack for ret prediction.
module pc_predict_unit #(
    parameter int unsigned       ADDR_W    = 64,
    parameter int unsigned       RAS_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         f_stall,
    input  logic [3:0]                   f_icode,
    input  logic [ADDR_W-1:0]            f_valC,
    input  logic [ADDR_W-1:0]            f_valP,
    input  logic [3:0]                   m_icode,
    input  logic                         m_cnd,
    input  logic [ADDR_W-1:0]            m_valA,
    input  logic [3:0]                   w_icode,
    input  logic                         w_ret_mispred,
    input  logic [ADDR_W-1:0]            w_valM,
    output logic [ADDR_W-1:0]            f_pc,
    output logic [ADDR_W-1:0]            pred_pc,
    output logic                         ras_hit,
    output logic                         redirect,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic [31:0]                  redirect_cnt
);

    localparam int unsigned PtrW = $clog2(RAS_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] CountMax = CntW'(RAS_DEPTH);

    localparam logic [3:0] IJxx  = 4'h7;
    localparam logic [3:0] ICall = 4'h8;
    localparam logic [3:0] IRet  = 4'h9;

    logic [ADDR_W-1:0] pred_pc_q, pred_pc_d;
    logic [PtrW-1:0]   top_q, top_d;
    logic [CntW-1:0]   ras_count_q, ras_count_d;
    logic [31:0]       redirect_cnt_q, redirect_cnt_d;
    logic [ADDR_W-1:0] ras_mem_q [RAS_DEPTH];
    logic [ADDR_W-1:0] ras_mem_d [RAS_DEPTH];

    logic            jmp_mispred;
    logic            ret_mispred;
    logic            flush;
    logic [CntW-1:0] count_eff;
    logic [PtrW-1:0] top_inc;
    logic [PtrW-1:0] top_dec;

    // Fetch PC select and RAS hit detection; a redirect empties the stack
    // before the corrected fetch sees it, unless fetch is stalled.
    always_comb begin
        jmp_mispred = (m_icode == IJxx) && !m_cnd;
        ret_mispred = (w_icode == IRet) && w_ret_mispred;
        redirect    = jmp_mispred || ret_mispred;
        if (jmp_mispred) begin
            f_pc = m_valA;
        end else if (ret_mispred) begin
            f_pc = w_valM;
        end else begin
            f_pc = pred_pc_q;
        end
        flush     = redirect && !f_stall;
        count_eff = flush ? '0 : ras_count_q;
        ras_hit   = (f_icode == IRet) && (count_eff != '0);
        top_inc   = top_q + 1'b1;
        top_dec   = top_q - 1'b1;
    end

    // Next prediction and RAS push/pop; stall freezes everything but the counter.
    always_comb begin
        pred_pc_d      = pred_pc_q;
        top_d          = top_q;
        ras_count_d    = ras_count_q;
        ras_mem_d      = ras_mem_q;
        redirect_cnt_d = redirect_cnt_q + 32'(redirect);
        if (!f_stall) begin
            ras_count_d = count_eff;
            pred_pc_d   = f_valP;
            case (f_icode)
                IJxx: begin
                    pred_pc_d = f_valC;
                end
                ICall: begin
                    pred_pc_d          = f_valC;
                    top_d              = top_inc;
                    ras_mem_d[top_inc] = f_valP;
                    // Full stack: the push overwrites the oldest entry.
                    if (count_eff != CountMax) begin
                        ras_count_d = count_eff + 1'b1;
                    end
                end
                IRet: begin
                    if (ras_hit) begin
                        pred_pc_d   = ras_mem_q[top_q];
                        top_d       = top_dec;
                        ras_count_d = count_eff - 1'b1;
                    end
                end
                default: begin
                    pred_pc_d = f_valP;
                end
            endcase
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pred_pc_q      <= RESET_PC;
            top_q          <= '0;
            ras_count_q    <= '0;
            redirect_cnt_q <= '0;
        end else begin
            pred_pc_q      <= pred_pc_d;
            top_q          <= top_d;
            ras_count_q    <= ras_count_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    // RAS entry storage; contents are meaningless while count is zero.
    always_ff @(posedge clk) begin
        ras_mem_q <= ras_mem_d;
    end

    assign pred_pc      = pred_pc_q;
    assign ras_count    = ras_count_q;
    assign redirect_cnt = redirect_cnt_q;

endmodule
